// File: rtl/rom_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : rom_read_arbiter
// Brief   : Two-requester read sequencer for a 32x8 ROM read port with
//           registered grant/valid handshake and a programmable access time.
//           Define ROM_ARB_FIXED_PRIO_EN for fixed priority (req[0] wins).
// Revision: 1.0
// ============================================================================
module rom_read_arbiter #(
   parameter int ADDR_W   = 5,
   parameter int DATA_W   = 8,
   parameter int WAIT_CYC = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        req,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   output logic [1:0]        gnt,
   output logic [1:0]        valid,
   output logic [DATA_W-1:0] data_o,
   output logic              busy,
   output logic [7:0]        rd_count,
   output logic [ADDR_W-1:0] rom_addr,
   output logic              rom_read_en,
   input  logic [DATA_W-1:0] rom_data
);

   localparam logic [3:0] c_wait_init = 4'(WAIT_CYC);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_RESP   = 2'd2
   } state_t;

   state_t              r_state, w_state_nxt;
   logic [3:0]          r_wait, w_wait_nxt;
   logic                r_win, w_win_nxt;
   logic [1:0]          r_gnt, w_gnt_nxt;
   logic [1:0]          r_valid, w_valid_nxt;
   logic [DATA_W-1:0]   r_data, w_data_nxt;
   logic [7:0]          r_count, w_count_nxt;
   logic [ADDR_W-1:0]   r_rom_addr, w_rom_addr_nxt;
   logic                r_rom_en, w_rom_en_nxt;
   logic                r_busy;
   logic                w_pick;

`ifdef ROM_ARB_FIXED_PRIO_EN
   assign w_pick = ~req[0];
`else
   logic r_last, w_last_nxt;

   // Under contention the requester that did not win last time is served.
   assign w_pick = (req == 2'b11) ? ~r_last : req[1];
`endif

   always_comb begin
      w_state_nxt    = r_state;
      w_wait_nxt     = r_wait;
      w_win_nxt      = r_win;
      w_gnt_nxt      = 2'b00;
      w_valid_nxt    = 2'b00;
      w_data_nxt     = r_data;
      w_count_nxt    = r_count;
      w_rom_addr_nxt = '0;
      w_rom_en_nxt   = 1'b0;
`ifndef ROM_ARB_FIXED_PRIO_EN
      w_last_nxt     = r_last;
`endif
      case (r_state)
         S_IDLE: begin
            if (req != 2'b00) begin
               w_state_nxt    = S_ACCESS;
               w_wait_nxt     = c_wait_init;
               w_win_nxt      = w_pick;
               w_gnt_nxt      = w_pick ? 2'b10 : 2'b01;
               w_rom_en_nxt   = 1'b1;
               w_rom_addr_nxt = w_pick ? addr1 : addr0;
`ifndef ROM_ARB_FIXED_PRIO_EN
               w_last_nxt     = w_pick;
`endif
            end
         end
         S_ACCESS: begin
            w_wait_nxt = r_wait - 4'd1;
            if (r_wait == 4'd1) begin
               // Last access cycle: ROM data is stable, capture and release the bus.
               w_state_nxt = S_RESP;
               w_data_nxt  = rom_data;
               w_valid_nxt = r_win ? 2'b10 : 2'b01;
               w_count_nxt = r_count + 8'd1;
            end else begin
               w_rom_en_nxt   = 1'b1;
               w_rom_addr_nxt = r_rom_addr;
            end
         end
         S_RESP: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_wait     <= 4'd0;
         r_win      <= 1'b0;
         r_gnt      <= 2'b00;
         r_valid    <= 2'b00;
         r_data     <= '0;
         r_count    <= 8'd0;
         r_rom_addr <= '0;
         r_rom_en   <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_wait     <= w_wait_nxt;
         r_win      <= w_win_nxt;
         r_gnt      <= w_gnt_nxt;
         r_valid    <= w_valid_nxt;
         r_data     <= w_data_nxt;
         r_count    <= w_count_nxt;
         r_rom_addr <= w_rom_addr_nxt;
         r_rom_en   <= w_rom_en_nxt;
         r_busy     <= (w_state_nxt != S_IDLE);
      end
   end

`ifndef ROM_ARB_FIXED_PRIO_EN
   // Reset to 1 so requester 0 wins the first contention.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_last <= 1'b1;
      end else begin
         r_last <= w_last_nxt;
      end
   end
`endif

   assign gnt         = r_gnt;
   assign valid       = r_valid;
   assign data_o      = r_data;
   assign busy        = r_busy;
   assign rd_count    = r_count;
   assign rom_addr    = r_rom_addr;
   assign rom_read_en = r_rom_en;

endmodule
`default_nettype wire

// File: tb/tb_rom_read_arbiter.sv
`default_nettype none
// tb_rom_read_arbiter: directed scoreboard bench; one instance with WAIT_CYC=1,
// one with WAIT_CYC=3, both reading a behavioural 32x8 ROM that floats when idle.
module tb_rom_read_arbiter;

`ifdef ROM_ARB_FIXED_PRIO_EN
   localparam bit FIXED_PRIO = 1'b1;
`else
   localparam bit FIXED_PRIO = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic [1:0] req, req3;
   logic [4:0] addr0, addr1, addr0_3, addr1_3;

   logic [1:0] gnt, valid, gnt3, valid3;
   logic [7:0] data_o, data3, rd_count, rd_count3;
   logic       busy, busy3, rom_read_en, rom_read_en3;
   logic [4:0] rom_addr, rom_addr3;
   wire  [7:0] rom_data, rom_data3;

   function automatic logic [7:0] rom_val(input logic [4:0] a);
      case (a)
         5'd0:    return 8'd21;
         5'd7:    return 8'd88;
         5'd8:    return 8'd28;
         5'd20:   return 8'd168;
         5'd31:   return 8'd111;
         default: return {a, 3'b101} ^ 8'h3c;
      endcase
   endfunction

   assign rom_data  = rom_read_en  ? rom_val(rom_addr)  : 8'bz;
   assign rom_data3 = rom_read_en3 ? rom_val(rom_addr3) : 8'bz;

   rom_read_arbiter #(.ADDR_W(5), .DATA_W(8), .WAIT_CYC(1)) dut (
      .clk(clk), .rst(rst), .req(req), .addr0(addr0), .addr1(addr1),
      .gnt(gnt), .valid(valid), .data_o(data_o), .busy(busy),
      .rd_count(rd_count), .rom_addr(rom_addr), .rom_read_en(rom_read_en),
      .rom_data(rom_data)
   );

   rom_read_arbiter #(.ADDR_W(5), .DATA_W(8), .WAIT_CYC(3)) dut3 (
      .clk(clk), .rst(rst), .req(req3), .addr0(addr0_3), .addr1(addr1_3),
      .gnt(gnt3), .valid(valid3), .data_o(data3), .busy(busy3),
      .rd_count(rd_count3), .rom_addr(rom_addr3), .rom_read_en(rom_read_en3),
      .rom_data(rom_data3)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic fail(input string name, input string what);
      n_vec++;
      n_err++;
      $display("FAIL %s: %s", name, what);
   endtask

   typedef struct {
      logic [1:0] g;
      logic [4:0] a;
   } gexp_t;

   typedef struct {
      logic [1:0] v;
      logic [7:0] d;
      logic [7:0] c;
      int         en_cyc;
   } rexp_t;

   gexp_t gq[$];
   rexp_t rq[$];
   rexp_t q3[$];
   logic [7:0] model_cnt;

   // Scoreboard for the WAIT_CYC=1 instance.
   int   en_run = 0;
   logic idle_bad = 1'b0;
   always @(negedge clk) begin
      gexp_t ge;
      rexp_t re;
      if (rst) begin
         en_run   = 0;
         idle_bad = 1'b0;
      end else begin
         if (gnt != 2'b00 && valid != 2'b00)
            fail("gnt_valid_excl", "gnt and valid both non-zero");
         if (gnt != 2'b00) begin
            en_run = 0;
            if (gq.size() == 0) fail("gnt_unexpected", "grant with no request queued");
            else begin
               ge = gq.pop_front();
               check("gnt", gnt, ge.g);
               check("rom_addr_access", rom_addr, ge.a);
            end
         end
         if (rom_read_en) en_run++;
         else if (rom_addr != 5'd0) idle_bad = 1'b1;
         if (valid != 2'b00) begin
            if (rq.size() == 0) fail("valid_unexpected", "valid with no request queued");
            else begin
               re = rq.pop_front();
               check("valid", valid, re.v);
               check("data_o", data_o, re.d);
               check("rd_count", rd_count, re.c);
               check("read_en_cycles", en_run, re.en_cyc);
               check("rom_addr_idle_zero", idle_bad, 0);
               check("busy_resp", busy, 1);
               idle_bad = 1'b0;
            end
         end
      end
   end

   // Scoreboard for the WAIT_CYC=3 instance, including grant-to-valid latency.
   int cyc3 = 0;
   int en3  = 0;
   always @(negedge clk) begin
      rexp_t re;
      if (rst) begin
         cyc3 = 0;
         en3  = 0;
      end else begin
         if (gnt3 != 2'b00) begin
            cyc3 = 0;
            en3  = 0;
         end
         if (rom_read_en3) en3++;
         cyc3++;
         if (valid3 != 2'b00) begin
            if (q3.size() == 0) fail("valid3_unexpected", "valid with no request queued");
            else begin
               re = q3.pop_front();
               check("valid3", valid3, re.v);
               check("data3", data3, re.d);
               check("rd_count3", rd_count3, re.c);
               check("read_en3_cycles", en3, re.en_cyc);
               check("latency3", cyc3, re.en_cyc + 1);
            end
         end
      end
   end

   // Called at a negedge while the DUT is idle; returns at the negedge of the following IDLE cycle.
   task automatic txn(input logic [1:0] r, input logic [4:0] a0, input logic [4:0] a1,
                      input logic w, input logic [7:0] exp_d);
      gexp_t ge;
      rexp_t re;
      bit    got;
      model_cnt = model_cnt + 8'd1;
      ge.g = w ? 2'b10 : 2'b01;
      ge.a = w ? a1 : a0;
      re.v = ge.g;
      re.d = exp_d;
      re.c = model_cnt;
      re.en_cyc = 1;
      gq.push_back(ge);
      rq.push_back(re);
      req   = r;
      addr0 = a0;
      addr1 = a1;
      got   = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (valid != 2'b00) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) fail("valid_timeout", "no valid within 20 cycles");
      req[w] = 1'b0;
      @(negedge clk);
      check("busy_idle", busy, 0);
      check("read_en_idle", rom_read_en, 0);
   endtask

   task automatic reset_pulse();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_cnt = 8'd0;
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      gexp_t ge;
      rexp_t re;
      bit    got;
      logic [4:0] a;
      req = 2'b00; addr0 = '0; addr1 = '0;
      req3 = 2'b00; addr0_3 = '0; addr1_3 = '0;
      model_cnt = 8'd0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_gnt", gnt, 0);
      check("rst_valid", valid, 0);
      check("rst_data", data_o, 0);
      check("rst_count", rd_count, 0);
      check("rst_read_en", rom_read_en, 0);
      check("rst_busy", busy, 0);
      check("rst_busy3", busy3, 0);
      rst = 1'b0;
      @(negedge clk);

      // Single requesters
      txn(2'b01, 5'd0, 5'd0, 1'b0, 8'd21);
      txn(2'b10, 5'd0, 5'd31, 1'b1, 8'd111);

      // Both requesting, each re-requests after its valid
      for (int k = 0; k < 4; k++) begin
         logic wk;
         wk = FIXED_PRIO ? 1'b0 : k[0];
         txn(2'b11, 5'd7, 5'd8, wk, wk ? 8'd28 : 8'd88);
         req = 2'b00;
      end

      // Reset during ACCESS abandons the read
      ge.g = 2'b01;
      ge.a = 5'd5;
      gq.push_back(ge);
      req = 2'b01; addr0 = 5'd5;
      @(negedge clk);
      #2 rst = 1'b1;
      req = 2'b00;
      #1;
      check("arst_gnt", gnt, 0);
      check("arst_valid", valid, 0);
      check("arst_data", data_o, 0);
      check("arst_count", rd_count, 0);
      check("arst_read_en", rom_read_en, 0);
      check("arst_rom_addr", rom_addr, 0);
      check("arst_busy", busy, 0);
      @(negedge clk);
      rst = 1'b0;
      model_cnt = 8'd0;
      repeat (3) @(negedge clk);
      txn(2'b11, 5'd7, 5'd8, 1'b0, 8'd88);
      req = 2'b00;

      // WAIT_CYC=3 instance
      re.v = 2'b01; re.d = 8'd168; re.c = 8'd1; re.en_cyc = 3;
      q3.push_back(re);
      req3 = 2'b01; addr0_3 = 5'd20;
      got = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (valid3 != 2'b00) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) fail("valid3_timeout", "no valid within 20 cycles");
      req3 = 2'b00;
      @(negedge clk);
      check("busy3_idle", busy3, 0);

      // 256 back-to-back reads wrap the counter
      reset_pulse();
      for (int i = 0; i < 256; i++) begin
         a = 5'(i);
         txn(2'b01, a, 5'd0, 1'b0, rom_val(a));
      end
      check("wrap_count", rd_count, 0);
      check("wrap_data", data_o, 111);

      check("gq_drained", gq.size(), 0);
      check("rq_drained", rq.size(), 0);
      check("q3_drained", q3.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
